// File: rtl/core_bus_arbiter.sv
// Core bus arbiter: merges instruction and data requests from the core
// onto one single-beat memory bus, with one-shot fairness after each beat.
package core_bus_pkg;
    typedef logic [2:0] msize_t;
    typedef logic [3:0] mlen_t;
    typedef logic [1:0] axi_burst_t;

    localparam msize_t     MSIZE4          = 3'b010;
    localparam mlen_t      MLEN1           = 4'b0000;
    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IFETCH  = 2'd1;
    localparam logic [1:0] DACCESS = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic        r_write;
    msize_t      r_size;
    logic [63:0] r_addr;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;
    logic        fair_set;
    logic        prefer_i;
    logic        busy;
    logic        done;
    logic        grant;
    logic        pick_i;

    assign busy  = (state != IDLE);
    assign done  = busy && cresp.ready && cresp.last;
    assign grant = (state == IDLE) && (ireq.valid || dreq.valid);

    // Fairness flag, once set by a completion, overrides DATA_FIRST on contention.
    always_comb begin
        pick_i = ireq.valid;
        if (ireq.valid && dreq.valid) begin
            pick_i = fair_set ? prefer_i : !DATA_FIRST;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_n = pick_i ? IFETCH : DACCESS;
                end
            end
            IFETCH, DACCESS: begin
                if (done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_strobe <= '0;
            r_data   <= '0;
            fair_set <= 1'b0;
            prefer_i <= 1'b0;
        end else begin
            state <= state_n;
            if (grant) begin
                if (pick_i) begin
                    r_write  <= 1'b0;
                    r_size   <= MSIZE4;
                    r_addr   <= ireq.addr;
                    r_strobe <= '0;
                    r_data   <= '0;
                end else begin
                    r_write  <= |dreq.strobe;
                    r_size   <= dreq.size;
                    r_addr   <= dreq.addr;
                    r_strobe <= dreq.strobe;
                    r_data   <= dreq.data;
                end
            end
            if (done) begin
                fair_set <= 1'b1;
                prefer_i <= (state == DACCESS);
            end
        end
    end

    always_comb begin
        creq          = '0;
        creq.valid    = busy;
        creq.is_write = r_write;
        creq.size     = r_size;
        creq.addr     = r_addr;
        creq.strobe   = r_strobe;
        creq.data     = r_data;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_FIXED;
    end

    // Fetches are 32-bit; addr[2] selects the word within the 64-bit beat.
    always_comb begin
        iresp         = '0;
        iresp.addr_ok = done && (state == IFETCH);
        iresp.data_ok = done && (state == IFETCH);
        iresp.data    = r_addr[2] ? cresp.data[63:32] : cresp.data[31:0];
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = done && (state == DACCESS);
        dresp.data_ok = done && (state == DACCESS);
        dresp.data    = cresp.data;
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: a cycle table plus a reset-abort sequence.
module tb_core_bus_arbiter;
    import core_bus_pkg::*;

    typedef struct {
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] da;
        logic [7:0]  ds;
        logic [63:0] dd;
        logic        rdy;
        logic        lst;
        logic [63:0] rd;
        logic        cv;
        logic [63:0] ca;
        logic        cw;
        logic [2:0]  csz;
        logic [7:0]  cs;
        logic [63:0] cd;
        logic        iok;
        logic        dok;
        logic [31:0] id;
        logic [63:0] dout;
    } vec_t;

    localparam logic        T   = 1'b1;
    localparam logic        F   = 1'b0;
    localparam logic [63:0] Z   = 64'h0;
    localparam logic [63:0] IA  = 64'h0000_0000_8000_0004;
    localparam logic [63:0] IB  = 64'h0000_0000_8000_0008;
    localparam logic [63:0] IC  = 64'h0000_0000_8000_000C;
    localparam logic [63:0] ID  = 64'h0000_0000_8000_0010;
    localparam logic [63:0] DA  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] DD  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DA2 = 64'h0000_0000_8000_1008;
    localparam logic [63:0] DD2 = 64'h0000_0000_0000_0002;
    localparam logic [63:0] M0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] M1  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] M2  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] M3  = 64'h9999_AAAA_BBBB_CCCC;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int tests = 0;
    int fails = 0;
    vec_t tbl[20];

    core_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ireq.valid   = v.iv;
        ireq.addr    = v.ia;
        dreq.valid   = v.dv;
        dreq.addr    = v.da;
        dreq.size    = 3'd3;
        dreq.strobe  = v.ds;
        dreq.data    = v.dd;
        cresp.ready  = v.rdy;
        cresp.last   = v.lst;
        cresp.data   = v.rd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("row%0d cvalid", i), 64'(creq.valid), 64'(v.cv));
        chk($sformatf("row%0d iok", i), 64'(iresp.data_ok), 64'(v.iok));
        chk($sformatf("row%0d iaok", i), 64'(iresp.addr_ok), 64'(v.iok));
        chk($sformatf("row%0d dok", i), 64'(dresp.data_ok), 64'(v.dok));
        chk($sformatf("row%0d daok", i), 64'(dresp.addr_ok), 64'(v.dok));
        if (v.cv) begin
            chk($sformatf("row%0d caddr", i), creq.addr, v.ca);
            chk($sformatf("row%0d cwrite", i), 64'(creq.is_write), 64'(v.cw));
            chk($sformatf("row%0d csize", i), 64'(creq.size), 64'(v.csz));
            chk($sformatf("row%0d cstrobe", i), 64'(creq.strobe), 64'(v.cs));
            chk($sformatf("row%0d cdata", i), creq.data, v.cd);
            chk($sformatf("row%0d clen", i), 64'(creq.len), 64'h0);
            chk($sformatf("row%0d cburst", i), 64'(creq.burst), 64'h0);
        end
        if (v.iok) begin
            chk($sformatf("row%0d idata", i), 64'(iresp.data), 64'(v.id));
        end
        if (v.dok) begin
            chk($sformatf("row%0d ddata", i), dresp.data, v.dout);
        end
    endtask

    initial begin
        // Columns: iv ia dv da ds dd rdy lst rd | cv ca cw csz cs cd iok dok id dout
        tbl[0]  = '{F,Z,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[1]  = '{T,IA,T,DA,8'hFF,DD,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[2]  = '{T,IA,T,DA,8'hFF,DD,F,F,Z, T,DA,T,3'd3,8'hFF,DD,F,F,32'h0,Z};
        tbl[3]  = '{T,IA,T,DA,8'hFF,DD,T,T,M0, T,DA,T,3'd3,8'hFF,DD,F,T,32'h0,M0};
        tbl[4]  = '{T,IA,T,DA2,8'h0F,DD2,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[5]  = '{T,IA,T,DA2,8'h0F,DD2,F,F,Z, T,IA,F,3'd2,8'h00,Z,F,F,32'h0,Z};
        tbl[6]  = '{T,IA,T,DA2,8'h0F,DD2,F,F,Z, T,IA,F,3'd2,8'h00,Z,F,F,32'h0,Z};
        tbl[7]  = '{T,IA,T,DA2,8'h0F,DD2,T,T,M1, T,IA,F,3'd2,8'h00,Z,T,F,32'h1111_2222,Z};
        tbl[8]  = '{F,Z,T,DA2,8'h0F,DD2,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[9]  = '{F,Z,T,DA2,8'h0F,DD2,T,F,M1, T,DA2,T,3'd3,8'h0F,DD2,F,F,32'h0,Z};
        tbl[10] = '{F,Z,T,DA2,8'h0F,DD2,T,F,M1, T,DA2,T,3'd3,8'h0F,DD2,F,F,32'h0,Z};
        tbl[11] = '{F,Z,T,DA2,8'h0F,DD2,T,T,M2, T,DA2,T,3'd3,8'h0F,DD2,F,T,32'h0,M2};
        tbl[12] = '{F,Z,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[13] = '{T,IB,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[14] = '{T,IB,F,Z,8'h00,Z,T,T,M1, T,IB,F,3'd2,8'h00,Z,T,F,32'h3333_4444,Z};
        tbl[15] = '{T,IC,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[16] = '{T,IC,F,Z,8'h00,Z,T,T,M2, T,IC,F,3'd2,8'h00,Z,T,F,32'h5555_6666,Z};
        tbl[17] = '{T,ID,F,Z,8'h00,Z,T,T,M2, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};
        tbl[18] = '{T,ID,F,Z,8'h00,Z,T,T,M3, T,ID,F,3'd2,8'h00,Z,T,F,32'hBBBB_CCCC,Z};
        tbl[19] = '{F,Z,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z};

        reset = 1'b1;
        drive(tbl[0]);
        repeat (2) @(negedge clk);
        #1;
        chk("reset cvalid", 64'(creq.valid), 64'h0);
        chk("reset caddr", creq.addr, Z);
        chk("reset iok", 64'(iresp.data_ok), 64'h0);
        chk("reset dok", 64'(dresp.data_ok), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec(i, tbl[i]);
        end

        // Reset while a data access is stalled aborts it silently.
        @(negedge clk);
        drive('{F,Z,T,DA,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z});
        #1;
        chk("abort pre cvalid", 64'(creq.valid), 64'h0);
        @(negedge clk);
        #1;
        chk("abort busy cvalid", 64'(creq.valid), 64'h1);
        chk("abort busy dok", 64'(dresp.data_ok), 64'h0);
        #1;
        reset = 1'b1;
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        #1;
        chk("abort rst cvalid", 64'(creq.valid), 64'h0);
        chk("abort rst caddr", creq.addr, Z);
        chk("abort rst dok", 64'(dresp.data_ok), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(tbl[0]);
        #1;
        chk("abort post cvalid", 64'(creq.valid), 64'h0);
        chk("abort post dok", 64'(dresp.data_ok), 64'h0);
        @(negedge clk);
        drive('{T,IA,F,Z,8'h00,Z,F,F,Z, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z});
        #1;
        chk("refetch idle cvalid", 64'(creq.valid), 64'h0);
        @(negedge clk);
        drive('{T,IA,F,Z,8'h00,Z,T,T,M1, F,Z,F,3'd0,8'h00,Z,F,F,32'h0,Z});
        #1;
        chk("refetch cvalid", 64'(creq.valid), 64'h1);
        chk("refetch caddr", creq.addr, IA);
        chk("refetch iok", 64'(iresp.data_ok), 64'h1);
        chk("refetch idata", 64'(iresp.data), 64'h1111_2222);
        chk("refetch dok", 64'(dresp.data_ok), 64'h0);
        @(negedge clk);
        drive(tbl[0]);
        #1;
        chk("refetch after cvalid", 64'(creq.valid), 64'h0);
        chk("refetch after iok", 64'(iresp.data_ok), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
